// File: rtl/lfsr_refill_arbiter.sv
// rtl/lfsr_refill_arbiter.sv - round-robin refill arbiter with LFSR victim-way selection
// Optional eviction counter enabled by defining LFSR_REFILL_ARB_PERF_EN.
module lfsr_refill_arbiter #(
    parameter int          NumReq  = 4,
    parameter int          NumWays = 8,
    parameter logic [15:0] SEED    = 16'h0000,
    localparam int         IdW     = (NumReq > 1) ? $clog2(NumReq) : 1,
    localparam int         WayW    = $clog2(NumWays)
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [NumReq-1:0]  req_i,
    output logic [NumReq-1:0]  gnt_o,
    input  logic [NumWays-1:0] valid_ways_i,
    input  logic [NumWays-1:0] lock_ways_i,
    input  logic               seed_load_i,
    input  logic [15:0]        seed_i,
    output logic               resp_valid_o,
    input  logic               resp_ready_i,
    output logic [IdW-1:0]     resp_id_o,
    output logic [NumWays-1:0] way_oh_o,
    output logic [WayW-1:0]    way_bin_o,
    output logic               all_locked_o,
    output logic [15:0]        evict_cnt_o
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEL,
        ST_RESP
    } state_t;

    localparam logic [15:0] SeedMapped = (SEED == 16'hFFFF) ? 16'h0000 : SEED;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [IdW-1:0]     r_rr_ptr;
    logic [IdW-1:0]     r_id;
    logic [WayW-1:0]    r_way_bin;
    logic [15:0]        r_lfsr;

    logic [IdW:0]       w_sum;
    logic [IdW-1:0]     w_gnt_idx;
    logic [IdW-1:0]     w_ptr_nxt;
    logic               w_req_found;
    logic               w_grant_ok;
    logic [NumWays-1:0] w_free;
    logic [WayW-1:0]    w_widx;
    logic [WayW-1:0]    w_victim;
    logic               w_way_found;
    logic [15:0]        w_lfsr_nxt;
    logic               w_hs;

    assign all_locked_o = &lock_ways_i;

    // Round-robin search starting at the requester after the last one granted.
    always_comb begin
        w_req_found = 1'b0;
        w_gnt_idx   = '0;
        w_sum       = '0;
        for (int i = 0; i < NumReq; i++) begin
            w_sum = {1'b0, r_rr_ptr} + (IdW+1)'(i);
            if (w_sum >= (IdW+1)'(NumReq)) begin
                w_sum = w_sum - (IdW+1)'(NumReq);
            end
            if (!w_req_found && req_i[w_sum[IdW-1:0]]) begin
                w_req_found = 1'b1;
                w_gnt_idx   = w_sum[IdW-1:0];
            end
        end
    end

    assign w_grant_ok = (r_state == ST_IDLE) && w_req_found && !all_locked_o;
    assign w_ptr_nxt  = (w_gnt_idx == IdW'(NumReq - 1)) ? '0 : w_gnt_idx + 1'b1;
    assign gnt_o      = (w_grant_ok && rst_ni) ? (NumReq'(1) << w_gnt_idx) : '0;

    // Invalid unlocked ways win; otherwise start at the LFSR way and skip locked ones.
    always_comb begin
        w_free      = ~valid_ways_i & ~lock_ways_i;
        w_victim    = r_lfsr[WayW-1:0];
        w_way_found = 1'b0;
        w_widx      = '0;
        for (int i = 0; i < NumWays; i++) begin
            if (!w_way_found && w_free[i]) begin
                w_victim    = WayW'(i);
                w_way_found = 1'b1;
            end
        end
        for (int i = 0; i < NumWays; i++) begin
            w_widx = r_lfsr[WayW-1:0] + WayW'(i);
            if (!w_way_found && !lock_ways_i[w_widx]) begin
                w_victim    = w_widx;
                w_way_found = 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_grant_ok) w_state_nxt = ST_SEL;
            ST_SEL:  w_state_nxt = ST_RESP;
            ST_RESP: if (resp_ready_i) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_hs       = (r_state == ST_RESP) && resp_ready_i;
    assign w_lfsr_nxt = {r_lfsr[14:0], ~(r_lfsr[15] ^ r_lfsr[12] ^ r_lfsr[5] ^ r_lfsr[1])};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state   <= ST_IDLE;
            r_rr_ptr  <= '0;
            r_id      <= '0;
            r_way_bin <= '0;
            r_lfsr    <= SeedMapped;
        end else begin
            r_state <= w_state_nxt;
            if (w_grant_ok) begin
                r_id     <= w_gnt_idx;
                r_rr_ptr <= w_ptr_nxt;
            end
            if (r_state == ST_SEL) begin
                r_way_bin <= w_victim;
            end
            // All-ones is the XNOR lock-up state, so it is never loaded.
            if (seed_load_i) begin
                r_lfsr <= (seed_i == 16'hFFFF) ? 16'h0000 : seed_i;
            end else if (w_hs) begin
                r_lfsr <= w_lfsr_nxt;
            end
        end
    end

    assign resp_valid_o = (r_state == ST_RESP);
    assign resp_id_o    = resp_valid_o ? r_id : '0;
    assign way_bin_o    = resp_valid_o ? r_way_bin : '0;
    assign way_oh_o     = resp_valid_o ? (NumWays'(1) << r_way_bin) : '0;

`ifdef LFSR_REFILL_ARB_PERF_EN
    logic        r_from_lfsr;
    logic [15:0] r_evict_cnt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_from_lfsr <= 1'b0;
            r_evict_cnt <= '0;
        end else begin
            if (r_state == ST_SEL) begin
                r_from_lfsr <= ~|w_free;
            end
            if (w_hs && r_from_lfsr && (r_evict_cnt != 16'hFFFF)) begin
                r_evict_cnt <= r_evict_cnt + 16'd1;
            end
        end
    end

    assign evict_cnt_o = r_evict_cnt;
`else
    assign evict_cnt_o = '0;
`endif

endmodule

// File: doc/lfsr_refill_arbiter.md
LFSR_REFILL_ARBITER -- requirements
Module: lfsr_refill_arbiter

Interface
REQ-001 SHALL have parameter NumReq, default 4, meaning number of refill requesters (1..8).
REQ-002 SHALL have parameter NumWays, default 8, meaning number of cache ways (power of two, 2..16).
REQ-003 SHALL have parameter SEED, 16-bit, default 16'h0000, meaning LFSR reset value.
REQ-004 SHALL have port clk_i  in  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_ni  in  1  asynchronous active-low reset.
REQ-006 SHALL have port req_i  in  NumReq  per-requester refill request, level, held until granted.
REQ-007 SHALL have port gnt_o  out  NumReq  one-hot grant pulse, one cycle.
REQ-008 SHALL have port valid_ways_i  in  NumWays  ways currently holding valid lines.
REQ-009 SHALL have port lock_ways_i  in  NumWays  ways excluded from replacement.
REQ-010 SHALL have port seed_load_i  in  1  load seed_i into LFSR this cycle.
REQ-011 SHALL have port seed_i  in  16  LFSR load value.
REQ-012 SHALL have port resp_valid_o  out  1  victim result valid.
REQ-013 SHALL have port resp_ready_i  in  1  consumer accepts result.
REQ-014 SHALL have port resp_id_o  out  $clog2(NumReq) (min 1)  index of granted requester.
REQ-015 SHALL have port way_oh_o / way_bin_o  out  NumWays / $clog2(NumWays)  victim way, one-hot and binary.
REQ-016 SHALL have port all_locked_o  out  1  combinational, high when lock_ways_i is all ones.
REQ-017 SHALL have port evict_cnt_o  out  16  count of random (non-invalid) victim selections.

Function
REQ-018 SHALL implement FSM IDLE -> SEL -> RESP -> IDLE.
REQ-019 SHALL in IDLE, when any req_i set and all_locked_o low, pulse gnt_o for one requester round-robin, latch its index, go SEL.
REQ-020 SHALL start round-robin search at (last granted index + 1) mod NumReq; after reset search starts at 0.
REQ-021 SHALL not grant while all_locked_o high; stays IDLE.
REQ-022 SHALL in SEL compute victim: lowest-index way with valid=0 and lock=0 if any exists; else way LFSR[$clog2(NumWays)-1:0], and if that way is locked, first unlocked way searching upward with wrap-around; latch result, go RESP.
REQ-023 SHALL sample valid_ways_i and lock_ways_i only in SEL.
REQ-024 SHALL in RESP hold resp_valid_o=1 and id/way outputs stable until resp_valid_o && resp_ready_i, then go IDLE.
REQ-025 SHALL give latency: gnt_o in cycle t, resp_valid_o first high in t+2; next grant no earlier than cycle after handshake.
REQ-026 SHALL ignore req_i in SEL and RESP; requests remain pending.
REQ-027 SHALL implement a 16-bit LFSR: next = {q[14:0], ~(q[15]^q[12]^q[5]^q[1])}.
REQ-028 SHALL advance the LFSR exactly once per completed response handshake.
REQ-029 SHALL give seed_load_i priority over advance, in any state; load value 16'hFFFF (XNOR lock-up) SHALL be replaced by 16'h0000.
REQ-030 SHALL drive way_oh_o/way_bin_o/resp_id_o to 0 whenever resp_valid_o is low.

Reset
REQ-031 SHALL on rst_ni low, asynchronously: FSM IDLE, LFSR=SEED (16'hFFFF mapped to 0), rr pointer 0, gnt_o 0, resp_valid_o 0, resp_id_o/way outputs 0, evict_cnt_o 0.
REQ-032 SHALL on reset mid-operation abandon the pending result with no handshake and no LFSR advance.

Configuration
REQ-033 SHALL with macro LFSR_REFILL_ARB_PERF_EN defined increment evict_cnt_o, saturating at 16'hFFFF, on each handshake whose victim came from the LFSR path.
REQ-034 SHALL without LFSR_REFILL_ARB_PERF_EN tie evict_cnt_o to 0 and instantiate no counter.

Verification
REQ-035 SHALL cover: SEED=0, req_i=4'b0001, valid=8'hFF, lock=0, ready=1 -> gnt_o=0001 at t, resp at t+2 way_bin_o=0; after handshake LFSR=16'h0001, next random victim way 1.
REQ-036 SHALL cover: req_i=4'b1111 held, ready=1 -> grants ordered 0,1,2,3,0.
REQ-037 SHALL cover: valid=8'hF7, lock=0 -> victim way 3 (one-hot 8'h08) regardless of LFSR; evict_cnt_o unchanged.
REQ-038 SHALL cover: valid=8'hFF, LFSR low bits=6, lock=8'hC0 -> victim way 0 (wrap); lock=8'hFF -> no grant, all_locked_o=1.
REQ-039 SHALL cover: resp_ready_i=0 for 5 cycles -> outputs stable, no grant; seed_load_i with 16'hFFFF -> LFSR reads 16'h0000.
REQ-040 SHALL cover: rst_ni low during RESP -> resp_valid_o=0 immediately, LFSR=SEED, evict_cnt_o=0.
